// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: receiver states and frame constants.
package uart_rx_fifo_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DEFAULT_DEPTH_LOG2   = 4;
    localparam int FRAME_BITS           = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_byte_fifo.sv
// Show-ahead FIFO: q always holds the head entry, registered from the RAM.
// Occupancy is tracked by a counter so full/empty never depend on pointer compare.
module byte_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      din_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      q_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  drop_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  empty_q, full_q;
    logic [WIDTH-1:0]      q_q, q_d;
    logic                  pop_eff, push_eff;

    always_comb begin
        pop_eff  = pop_i && !empty_q;
        push_eff = push_i && (!full_q || pop_eff);
        drop_o   = push_i && full_q && !pop_eff;

        wr_ptr_d = push_eff ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_eff  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (push_eff && !pop_eff) begin
            count_d = count_q + 1'b1;
        end else if (pop_eff && !push_eff) begin
            count_d = count_q - 1'b1;
        end

        // New head is being written this cycle (empty push, or push+pop at count 1): bypass RAM.
        if (push_eff && (wr_ptr_q == rd_ptr_d)) begin
            q_d = din_i;
        end else begin
            q_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            q_q      <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == COUNT_FULL);
            q_q      <= q_d;
        end
    end

    assign q_o     = q_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;
    assign count_o = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO toward the core's UART port.
//   state    | meaning
//   ST_IDLE  | line idle, waiting for a falling edge on rx_s
//   ST_START | timing to mid start bit to confirm it is not a glitch
//   ST_DATA  | sampling 8 data bits, LSB first, one per bit period
//   ST_STOP  | sampling the stop bit; push on 1, frame error on 0
//   ST_BREAK | line held low after a frame error; wait for idle
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DEPTH_LOG2   = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rxd,
    input  logic                  rdreq,
    output logic [7:0]            q,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    output logic                  frame_err
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [TW-1:0] T_MID  = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(FRAME_BITS - 1);

    logic                  rx_meta_q, rx_s_q;
    rx_state_e             state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  push;
    logic                  frame_err_d, frame_err_q;
    logic                  drop, overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rxd;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= drop;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (!rx_s_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (timer_q == T_MID) begin
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (timer_q == T_LAST) begin
                    timer_d   = '0;
                    shift_d   = {rx_s_q, shift_q[FRAME_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == B_LAST) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // Leave at mid stop bit so a start bit immediately following is caught.
                if (timer_q == T_LAST) begin
                    timer_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                timer_d = '0;
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                timer_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    byte_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (shift_q),
        .pop_i   (rdreq),
        .q_o     (q),
        .empty_o (empty),
        .full_o  (full),
        .count_o (count),
        .drop_o  (drop)
    );

    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 8 clocks per bit and a 16-entry FIFO.
module tb_uart_rx_fifo;

    localparam int CPB = 8;
    localparam int DL2 = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rxd;
    logic         rdreq;
    logic [7:0]   q;
    logic         empty;
    logic         full;
    logic [DL2:0] count;
    logic         overrun;
    logic         frame_err;

    int n_vec = 0;
    int n_err = 0;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .rdreq     (rdreq),
        .q         (q),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_head(input logic [7:0] d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_head(d);
        drive_bit(stop);
    endtask

    task automatic pop();
        rdreq = 1'b1;
        @(posedge clk);
        #1;
        rdreq = 1'b0;
    endtask

    task automatic idle_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        rxd   = 1'b1;
        rdreq = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_empty", 16'(empty), 16'h1);
        check("rst_full", 16'(full), 16'h0);
        check("rst_count", 16'(count), 16'h0);
        check("rst_q", 16'(q), 16'h0);
        check("rst_overrun", 16'(overrun), 16'h0);
        check("rst_frame_err", 16'(frame_err), 16'h0);
        rst_n = 1'b1;
        idle_clks(4);

        // 1: single byte, push visible one clock after the stop-bit sample
        send_head(8'hA5);
        rxd = 1'b1;
        repeat (CPB - 1) @(posedge clk);
        #4;
        check("t1_empty_before_push", 16'(empty), 16'h1);
        @(posedge clk);
        #1;
        check("t1_empty_after_push", 16'(empty), 16'h0);
        check("t1_q", 16'(q), 16'hA5);
        check("t1_count", 16'(count), 16'h1);
        pop();
        check("t1_empty_after_pop", 16'(empty), 16'h1);
        check("t1_count_after_pop", 16'(count), 16'h0);

        // 2: fill to full, overflow by one, drain in order
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
        check("t2_full", 16'(full), 16'h1);
        check("t2_count16", 16'(count), 16'd16);
        check("t2_no_overrun_yet", 16'(overrun), 16'h0);
        send_byte(8'h10, 1'b1);
        check("t2_overrun_pulse", 16'(overrun), 16'h1);
        check("t2_count_still16", 16'(count), 16'd16);
        idle_clks(1);
        check("t2_overrun_clears", 16'(overrun), 16'h0);
        for (int i = 0; i < 16; i++) begin
            check("t2_read_q", 16'(q), 16'(i));
            pop();
        end
        check("t2_empty_after_drain", 16'(empty), 16'h1);
        check("t2_count_after_drain", 16'(count), 16'h0);

        // 3: bad stop bit, line held low, then a good frame
        send_byte(8'h3C, 1'b0);
        check("t3_frame_err_pulse", 16'(frame_err), 16'h1);
        check("t3_count0", 16'(count), 16'h0);
        idle_clks(1);
        check("t3_frame_err_clears", 16'(frame_err), 16'h0);
        idle_clks(3 * CPB);
        check("t3_count0_in_break", 16'(count), 16'h0);
        rxd = 1'b1;
        idle_clks(2 * CPB);
        send_byte(8'h3C, 1'b1);
        check("t3_q_good", 16'(q), 16'h3C);
        check("t3_count1", 16'(count), 16'h1);
        check("t3_no_frame_err", 16'(frame_err), 16'h0);
        pop();

        // 4: two-clock glitch rejected, next frame still decodes
        rxd = 1'b0;
        idle_clks(2);
        rxd = 1'b1;
        idle_clks(3 * CPB);
        check("t4_glitch_empty", 16'(empty), 16'h1);
        check("t4_glitch_count", 16'(count), 16'h0);
        check("t4_glitch_frame_err", 16'(frame_err), 16'h0);
        send_byte(8'h81, 1'b1);
        check("t4_q", 16'(q), 16'h81);
        check("t4_count1", 16'(count), 16'h1);

        // 5: reset during bit 4 of a frame, with 0x81 still queued
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        rxd = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_empty", 16'(empty), 16'h1);
        check("t5_rst_count", 16'(count), 16'h0);
        check("t5_rst_q", 16'(q), 16'h0);
        check("t5_rst_full", 16'(full), 16'h0);
        check("t5_rst_overrun", 16'(overrun), 16'h0);
        check("t5_rst_frame_err", 16'(frame_err), 16'h0);
        rxd = 1'b1;
        idle_clks(3);
        rst_n = 1'b1;
        idle_clks(2 * CPB);
        send_byte(8'h5A, 1'b1);
        check("t5_q", 16'(q), 16'h5A);
        check("t5_count1", 16'(count), 16'h1);
        pop();

        // 6: push and pop in the same cycle while full
        for (int i = 0; i < 16; i++) send_byte(8'(8'h60 + i), 1'b1);
        check("t6_full", 16'(full), 16'h1);
        send_head(8'h77);
        rxd = 1'b1;
        repeat (CPB - 1) @(posedge clk);
        #1;
        rdreq = 1'b1;
        @(posedge clk);
        #1;
        rdreq = 1'b0;
        check("t6_count16", 16'(count), 16'd16);
        check("t6_no_overrun", 16'(overrun), 16'h0);
        check("t6_still_full", 16'(full), 16'h1);
        for (int i = 1; i < 16; i++) begin
            check("t6_read_q", 16'(q), 16'(8'h60 + i));
            pop();
        end
        check("t6_last_q", 16'(q), 16'h77);
        pop();
        check("t6_empty_end", 16'(empty), 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
